dvp_capture_ctrl: RTL and testbench
===================================

# dvp_capture_ctrl

Frame capture controller between the DVP receiver's AXI-Stream output and the downstream frame sink.

- Arms and disarms capture on command and aligns capture to the start-of-frame beat.
- Checks line length and frame height against the configured geometry.
- Buffers one beat toward a back-pressured sink. The receiver cannot be stalled, so a stall that would lose data is detected, and the damaged frame is dropped until the next frame start.

## Interface

- BYTES_PER_LINE, 1280, expected beats per line (640 px YUV422).
- LINES, 480, expected lines per frame.
- CNT_W, 12, width of the beat and line counters. Must hold BYTES_PER_LINE and LINES.
- pclk  in  1  pixel clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  8  stream from receiver.
- s_tvalid  in  1  beat valid; no tready is returned.
- s_tlast  in  1  end of line.
- s_tuser  in  1  start of frame.
- start  in  1  one-cycle pulse that arms capture.
- stop  in  1  one-cycle pulse that disarms capture.
- continuous  in  1  1 = re-arm after each frame; 0 = single frame.
- clr_err  in  1  clears the sticky error flags.
- m_tdata  out  8  stream to sink.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  sink ready.
- m_tlast  out  1  end of line, forwarded.
- m_tuser  out  1  start of frame, forwarded.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse when a full frame has been accepted.
- frame_cnt  out  16  completed frames; wraps modulo 2^16.
- err_overflow  out  1  sticky: a beat was lost to back-pressure.
- err_geometry  out  1  sticky: a line-length or frame-height mismatch was seen.

## Operation

**States**

- **IDLE.** Input beats are ignored.
  - start → WAIT_SOF.
- **WAIT_SOF.** Beats without s_tuser are discarded.
  - A beat with s_tuser → CAPTURE; that beat is forwarded and counted.
  - stop → IDLE.
- **CAPTURE.** Every beat is loaded into the output register and byte_cnt increments.
  - On s_tlast: if byte_cnt+1 ≠ BYTES_PER_LINE, set err_geometry. Then clear byte_cnt and increment line_cnt.
  - On s_tlast with line_cnt = LINES-1: pulse frame_done, increment frame_cnt, clear the counters. Next state is WAIT_SOF if continuous=1 and no stop is pending; otherwise IDLE.
  - stop during CAPTURE sets stop_pending. The current frame completes, then the block goes to IDLE.
  - s_tuser mid-frame (any beat other than the first): set err_geometry, abandon the frame without frame_done, restart the counters, and capture the beat as the first beat of a new frame.
- **DROP.** Beats are discarded.
  - A beat with s_tuser: if continuous=1 and no stop is pending, go to CAPTURE and forward that beat; otherwise go to IDLE.
  - stop → IDLE.

**Output register (one entry)**

- Accepts a beat when it is empty, or when m_tvalid & m_tready in the same cycle (full throughput).
- Overflow: a beat arrives in CAPTURE while m_tvalid=1 and m_tready=0.
  - Set err_overflow, drop the beat, enter DROP, clear the counters.
  - The beat already held in the register is still delivered.

**Command and flag rules**

- start while busy is ignored.
- start and stop in the same cycle: stop wins.
- stop_pending clears on entry to IDLE.
- Sticky flags are set/clear: a set in the same cycle as clr_err wins.
- Counter arithmetic is CNT_W bits. byte_cnt saturates at all-ones, so an overlong line still flags a mismatch at s_tlast.

## Timing

- Latency: s_tvalid beat in cycle n → m_tvalid in cycle n+1 when the register was empty. Data, last and user bits travel together.
- frame_done is asserted in the cycle after the final s_tlast beat, coincident with that beat's m_tvalid.
- State, counters and flags update on the rising edge of pclk.
- On rst, asynchronously:
  - state = IDLE; all counters 0.
  - m_tvalid, m_tlast, m_tuser, busy, frame_done, err_overflow, err_geometry = 0; frame_cnt = 0; m_tdata = 0.
- Reset mid-frame discards the buffered beat. After release, capture resumes only after a new start.

## Structure

- Package dvp_pkg holds the state enum (IDLE, WAIT_SOF, CAPTURE, DROP) and the default geometry constants shared with other DVP blocks.
- Sub-module dvp_skid_reg implements the one-entry output register and its overflow detection. The FSM, counters and flags stay in the top module.

## Test plan

Benches use BYTES_PER_LINE=4, LINES=3, with m_tready tied high unless stated.

- **Single frame.** continuous=0; start, then 3 lines of 4 beats (0x00..0x0B), tuser on the first beat.
  - 12 beats out, m_tuser on 0x00 only, m_tlast on 0x03/0x07/0x0B.
  - frame_done once, frame_cnt=1, then IDLE.
- **Continuous mode.** 2 back-to-back frames.
  - frame_cnt=2, busy stays 1.
  - stop during frame 2 → frame 2 still completes, then busy=0.
- **Short line.** Line 2 has 3 beats.
  - err_geometry=1 after its tlast; frame_done is still pulsed after line 3.
  - clr_err → flag returns to 0.
- **Early SOF.** tuser arrives on beat 6.
  - err_geometry=1, no frame_done.
  - A complete frame then follows from beat 6 and frame_done fires after 12 beats.
- **Back-pressure.** m_tready=0 for 2 cycles during a line.
  - err_overflow=1 and the buffered beat is still delivered.
  - Remaining beats are dropped; the next tuser frame is captured when continuous=1.
- **Reset and command conflicts.**
  - rst asserted mid-line → all outputs 0 immediately.
  - start and stop in the same cycle → stays IDLE.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared DVP definitions: default frame geometry, capture FSM states and the
// beat record carried through the output register.
package dvp_pkg;

  localparam int DVP_BYTES_PER_LINE = 1280;
  localparam int DVP_LINES          = 480;
  localparam int DVP_CNT_W          = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_DROP
  } dvp_state_e;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } dvp_beat_t;

endpackage

// File: rtl/dvp_capture_ctrl_if.sv
// Stream bundle around the capture controller: receiver-side input stream
// (no tready) and the back-pressured sink-side output stream.
interface dvp_capture_ctrl_if;

  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tuser;

  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       m_tuser;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    output m_tdata, m_tvalid, m_tlast, m_tuser
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tuser
  );

endinterface

// File: rtl/dvp_skid_reg.sv
// One-entry output register toward the sink. Since the source cannot be
// stalled, a beat offered while the entry is stuck is flagged as overflow.
module dvp_skid_reg
  import dvp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_valid,
  input  dvp_beat_t i_beat,
  input  logic      i_ready,
  output logic      o_valid,
  output dvp_beat_t o_beat,
  output logic      o_overflow
);

  logic      r_valid;
  dvp_beat_t r_beat;
  logic      w_load;

  assign o_overflow = i_valid & r_valid & ~i_ready;
  assign w_load     = i_valid & ~o_overflow;

  // Loading while the held beat is being taken keeps full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_beat  = r_beat;

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame capture controller: arms on command, aligns to start-of-frame, checks
// line/frame geometry and drops frames damaged by sink back-pressure.
module dvp_capture_ctrl
  import dvp_pkg::*;
#(
  parameter int BYTES_PER_LINE = DVP_BYTES_PER_LINE,
  parameter int LINES          = DVP_LINES,
  parameter int CNT_W          = DVP_CNT_W
) (
  input  logic              pclk,
  input  logic              rst,
  dvp_capture_ctrl_if.slave bus,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              clr_err,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_overflow,
  output logic              err_geometry
);

  localparam logic [CNT_W-1:0] BPL_C       = CNT_W'(BYTES_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_LINE_C = CNT_W'(LINES - 1);
  localparam logic [CNT_W-1:0] SAT_C       = '1;

  dvp_state_e       r_state, w_stateNext;
  logic [CNT_W-1:0] r_byteCnt, w_byteCntNext;
  logic [CNT_W-1:0] r_lineCnt, w_lineCntNext;
  logic [CNT_W-1:0] w_bcBase, w_lcBase, w_bcInc;
  logic             r_stopPend, w_stopPendNext;
  logic             r_frameDone, w_frameDone;
  logic [15:0]      r_frameCnt;
  logic             r_errOvf, r_errGeom;
  logic             w_setOvf, w_setGeom;
  logic             w_take, w_restart, w_midSof, w_overflow;
  logic             w_outValid;
  dvp_beat_t        w_inBeat, w_outBeat;

  // A beat is offered to the output register only when the FSM wants it.
  assign w_take = bus.s_tvalid & (
                    ((r_state == ST_WAIT_SOF) & ~stop & bus.s_tuser) |
                    (r_state == ST_CAPTURE) |
                    ((r_state == ST_DROP) & ~stop & bus.s_tuser & continuous & ~r_stopPend));
  assign w_restart = w_take & ((r_state != ST_CAPTURE) | bus.s_tuser);
  assign w_midSof  = w_take & (r_state == ST_CAPTURE) & bus.s_tuser;
  assign w_bcBase  = w_restart ? '0 : r_byteCnt;
  assign w_lcBase  = w_restart ? '0 : r_lineCnt;
  assign w_bcInc   = w_bcBase + CNT_W'(1);
  assign w_inBeat  = {bus.s_tuser, bus.s_tlast, bus.s_tdata};

  dvp_skid_reg u_skid (
    .clk        (pclk),
    .rst        (rst),
    .i_valid    (w_take),
    .i_beat     (w_inBeat),
    .i_ready    (bus.m_tready),
    .o_valid    (w_outValid),
    .o_beat     (w_outBeat),
    .o_overflow (w_overflow)
  );

  always_comb begin
    w_stateNext    = r_state;
    w_byteCntNext  = r_byteCnt;
    w_lineCntNext  = r_lineCnt;
    w_stopPendNext = r_stopPend;
    w_frameDone    = 1'b0;
    w_setOvf       = 1'b0;
    w_setGeom      = w_midSof;

    case (r_state)
      ST_IDLE:     if (start & ~stop) w_stateNext = ST_WAIT_SOF;
      ST_WAIT_SOF: if (stop) w_stateNext = ST_IDLE;
      ST_CAPTURE:  if (stop) w_stopPendNext = 1'b1;
      ST_DROP: begin
        if (stop) w_stateNext = ST_IDLE;
        else if (bus.s_tvalid & bus.s_tuser & ~w_take) w_stateNext = ST_IDLE;
      end
      default:     w_stateNext = ST_IDLE;
    endcase

    // Beat bookkeeping; a lost beat abandons the frame until the next SOF.
    if (w_take) begin
      if (w_overflow) begin
        w_setOvf      = 1'b1;
        w_stateNext   = ST_DROP;
        w_byteCntNext = '0;
        w_lineCntNext = '0;
      end else begin
        w_stateNext = ST_CAPTURE;
        if (bus.s_tlast) begin
          if (w_bcInc != BPL_C) w_setGeom = 1'b1;
          w_byteCntNext = '0;
          if (w_lcBase == LAST_LINE_C) begin
            w_frameDone   = 1'b1;
            w_lineCntNext = '0;
            w_stateNext   = (continuous & ~(r_stopPend | stop)) ? ST_WAIT_SOF : ST_IDLE;
          end else begin
            w_lineCntNext = w_lcBase + CNT_W'(1);
          end
        end else begin
          w_byteCntNext = (w_bcBase == SAT_C) ? w_bcBase : w_bcInc;
          w_lineCntNext = w_lcBase;
        end
      end
    end

    if (w_stateNext == ST_IDLE) w_stopPendNext = 1'b0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_byteCnt   <= '0;
      r_lineCnt   <= '0;
      r_stopPend  <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameCnt  <= '0;
      r_errOvf    <= 1'b0;
      r_errGeom   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_byteCnt   <= w_byteCntNext;
      r_lineCnt   <= w_lineCntNext;
      r_stopPend  <= w_stopPendNext;
      r_frameDone <= w_frameDone;
      r_frameCnt  <= r_frameCnt + {15'd0, w_frameDone};
      if (w_setOvf) r_errOvf <= 1'b1;
      else if (clr_err) r_errOvf <= 1'b0;
      if (w_setGeom) r_errGeom <= 1'b1;
      else if (clr_err) r_errGeom <= 1'b0;
    end
  end

  assign bus.m_tvalid = w_outValid;
  assign bus.m_tdata  = w_outBeat.data;
  assign bus.m_tlast  = w_outBeat.last;
  assign bus.m_tuser  = w_outBeat.user;

  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = r_frameDone;
  assign frame_cnt    = r_frameCnt;
  assign err_overflow = r_errOvf;
  assign err_geometry = r_errGeom;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl with a 4-beat x 3-line geometry.
module tb_dvp_capture_ctrl;

   logic        pclk = 1'b0;
   logic        rst;
   logic        start, stop, continuous, clr_err;
   logic        busy, frame_done, err_overflow, err_geometry;
   logic [15:0] frame_cnt;

   int errors = 0;
   int checks = 0;
   int doneCount = 0;
   int doneBase;
   int outBase;
   logic [9:0] outQ[$];

   dvp_capture_ctrl_if bus();

   dvp_capture_ctrl #(
      .BYTES_PER_LINE (4),
      .LINES          (3),
      .CNT_W          (12)
   ) dut (
      .pclk         (pclk),
      .rst          (rst),
      .bus          (bus),
      .start        (start),
      .stop         (stop),
      .continuous   (continuous),
      .clr_err      (clr_err),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt),
      .err_overflow (err_overflow),
      .err_geometry (err_geometry)
   );

   // Free-running pixel clock, 10 time units per cycle.
   always #5 pclk = ~pclk;

   // Record every completed output handshake and frame_done pulse mid-cycle.
   always @(negedge pclk) begin
      if (rst === 1'b0) begin
         if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1)
            outQ.push_back({bus.m_tuser, bus.m_tlast, bus.m_tdata});
         if (frame_done === 1'b1)
            doneCount++;
      end
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Present one input beat for one clock cycle.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic u);
      bus.s_tvalid = v;
      bus.s_tdata  = d;
      bus.s_tlast  = l;
      bus.s_tuser  = u;
      tick();
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Reset between scenarios and rebase the monitor bookkeeping.
   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      outBase  = outQ.size();
      doneBase = doneCount;
      tick();
   endtask

   // A well-formed 12-beat frame starting at data value base.
   task automatic sendFrame(input logic [7:0] base);
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b1, base + 8'(i), (i % 4) == 3, i == 0);
   endtask

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      continuous   = 1'b0;
      clr_err      = 1'b0;
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = 8'h00;
      bus.s_tlast  = 1'b0;
      bus.s_tuser  = 1'b0;
      bus.m_tready = 1'b1;
      #1 rst = 1'b1;
      tick();

      // Reset state
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
      checkOutput("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      checkOutput("rst_err_overflow", 32'(err_overflow), 32'd0);
      checkOutput("rst_err_geometry", 32'(err_geometry), 32'd0);
      rst = 1'b0;
      outBase  = outQ.size();
      doneBase = doneCount;
      tick();

      // Single frame, continuous=0
      $display("[TB] single frame");
      continuous = 1'b0;
      pulseStart();
      checkOutput("t1_busy_armed", 32'(busy), 32'd1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("t1_latency_valid", 32'(bus.m_tvalid), 32'd1);
      checkOutput("t1_latency_user", 32'(bus.m_tuser), 32'd1);
      for (int i = 1; i < 12; i++)
         applyStimulus(1'b1, 8'(i), (i % 4) == 3, 1'b0);
      checkOutput("t1_done_pulse", 32'(frame_done), 32'd1);
      checkOutput("t1_done_last", 32'(bus.m_tlast), 32'd1);
      idleCycles(2);
      checkOutput("t1_done_cleared", 32'(frame_done), 32'd0);
      checkOutput("t1_out_count", outQ.size() - outBase, 32'd12);
      for (int i = 0; i < 12; i++) begin
         logic [9:0] expBeat;
         expBeat = {i == 0, (i % 4) == 3, 8'(i)};
         checkOutput($sformatf("t1_beat%0d", i), 32'(outQ[outBase + i]), 32'(expBeat));
      end
      checkOutput("t1_done_count", doneCount - doneBase, 32'd1);
      checkOutput("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("t1_busy_idle", 32'(busy), 32'd0);
      checkOutput("t1_err_geometry", 32'(err_geometry), 32'd0);

      // Continuous mode, stop during frame 2
      $display("[TB] continuous mode");
      doReset();
      continuous = 1'b1;
      pulseStart();
      sendFrame(8'h10);
      idleCycles(1);
      checkOutput("t2_busy_after_f1", 32'(busy), 32'd1);
      checkOutput("t2_frame_cnt_f1", 32'(frame_cnt), 32'd1);
      for (int i = 0; i < 12; i++) begin
         stop = (i == 5);
         applyStimulus(1'b1, 8'h40 + 8'(i), (i % 4) == 3, i == 0);
         if (i == 6) checkOutput("t2_busy_after_stop", 32'(busy), 32'd1);
      end
      stop = 1'b0;
      checkOutput("t2_done_f2", 32'(frame_done), 32'd1);
      idleCycles(2);
      checkOutput("t2_frame_cnt_f2", 32'(frame_cnt), 32'd2);
      checkOutput("t2_done_count", doneCount - doneBase, 32'd2);
      checkOutput("t2_busy_stopped", 32'(busy), 32'd0);

      // Short second line
      $display("[TB] short line");
      doReset();
      continuous = 1'b0;
      pulseStart();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), i == 3, i == 0);
      checkOutput("t3_geom_line1", 32'(err_geometry), 32'd0);
      for (int i = 4; i < 7; i++) applyStimulus(1'b1, 8'(i), i == 6, 1'b0);
      checkOutput("t3_geom_line2", 32'(err_geometry), 32'd1);
      for (int i = 7; i < 11; i++) applyStimulus(1'b1, 8'(i), i == 10, 1'b0);
      checkOutput("t3_done_pulse", 32'(frame_done), 32'd1);
      idleCycles(1);
      checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("t3_geom_sticky", 32'(err_geometry), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checkOutput("t3_geom_cleared", 32'(err_geometry), 32'd0);

      // Early SOF on beat 6
      $display("[TB] early sof");
      doReset();
      continuous = 1'b0;
      pulseStart();
      for (int j = 0; j < 6; j++) applyStimulus(1'b1, 8'(j), j == 3, j == 0);
      for (int j = 6; j < 18; j++) begin
         applyStimulus(1'b1, 8'(j), ((j - 6) % 4) == 3, j == 6);
         if (j == 6) begin
            checkOutput("t4_geom_early_sof", 32'(err_geometry), 32'd1);
            checkOutput("t4_no_done_yet", doneCount - doneBase, 32'd0);
         end
      end
      checkOutput("t4_done_pulse", 32'(frame_done), 32'd1);
      idleCycles(2);
      checkOutput("t4_done_count", doneCount - doneBase, 32'd1);
      checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("t4_out_count", outQ.size() - outBase, 32'd18);
      checkOutput("t4_restart_beat", 32'(outQ[outBase + 6]), 32'h206);

      // Back-pressure overflow, recovery on next SOF
      $display("[TB] back-pressure");
      doReset();
      continuous = 1'b1;
      pulseStart();
      for (int j = 0; j < 5; j++) applyStimulus(1'b1, 8'(j), j == 3, j == 0);
      bus.m_tready = 1'b0;
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
      checkOutput("t5_err_overflow", 32'(err_overflow), 32'd1);
      checkOutput("t5_held_valid", 32'(bus.m_tvalid), 32'd1);
      checkOutput("t5_held_data", 32'(bus.m_tdata), 32'h04);
      applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
      bus.m_tready = 1'b1;
      applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
      checkOutput("t5_drained", 32'(bus.m_tvalid), 32'd0);
      for (int j = 8; j < 12; j++) applyStimulus(1'b1, 8'(j), j == 11, 1'b0);
      checkOutput("t5_dropped_tail", outQ.size() - outBase, 32'd5);
      sendFrame(8'h20);
      checkOutput("t5_done_pulse", 32'(frame_done), 32'd1);
      idleCycles(2);
      checkOutput("t5_out_count", outQ.size() - outBase, 32'd17);
      checkOutput("t5_held_delivered", 32'(outQ[outBase + 4]), 32'h004);
      checkOutput("t5_next_sof", 32'(outQ[outBase + 5]), 32'h220);
      checkOutput("t5_frame_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("t5_busy", 32'(busy), 32'd1);

      // Reset mid-line, then command conflicts
      $display("[TB] reset and commands");
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
      bus.s_tvalid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
      checkOutput("t6_rst_m_tdata", 32'(bus.m_tdata), 32'd0);
      checkOutput("t6_rst_m_tuser", 32'(bus.m_tuser), 32'd0);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      checkOutput("t6_rst_err_overflow", 32'(err_overflow), 32'd0);
      tick();
      rst = 1'b0;
      outBase = outQ.size();
      tick();
      applyStimulus(1'b1, 8'h40, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
      idleCycles(2);
      checkOutput("t6_no_capture_unarmed", outQ.size() - outBase, 32'd0);
      checkOutput("t6_busy_unarmed", 32'(busy), 32'd0);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      checkOutput("t6_start_stop_busy", 32'(busy), 32'd0);
      applyStimulus(1'b1, 8'h50, 1'b0, 1'b1);
      idleCycles(2);
      checkOutput("t6_start_stop_no_capture", outQ.size() - outBase, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
